// File: rtl/idct_1d_column1.sv
// One-dimensional 8-point IDCT column stage. Only Y0..Y3 are used.
// Two register stages: S1 holds the even/odd terms and S2 the saturated samples.
// Both stages advance together under a single enable. That enable also drives in_ready.
module idct_1d_column1 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] in_coef,
    input  logic [2:0]  count1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [71:0] out_pix,
    output logic        out_last,
    output logic        out_sat
);

    localparam int unsigned CW = 10;   // coefficient width
    localparam int unsigned IW = 14;   // intermediate width
    localparam int unsigned PW = 9;    // output sample width
    localparam int unsigned NT = 4;    // even/odd term count

    localparam logic signed [IW-1:0] PIX_MAX = 14'sd255;
    localparam logic signed [IW-1:0] PIX_MIN = -14'sd256;
    localparam logic [2:0]           HI_GAIN_ROW = 3'b010;

    // Pipeline state
    logic                 s1_valid_q;
    logic signed [IW-1:0] e_q [NT];
    logic signed [IW-1:0] o_q [NT];
    logic                 out_valid_q;
    logic [71:0]          out_pix_q;
    logic                 out_sat_q;
    logic [2:0]           col_q;

    // Next-state values
    logic signed [IW-1:0] e_d [NT];
    logic signed [IW-1:0] o_d [NT];
    logic [71:0]          pix_d;
    logic                 sat_d;

    logic                 en;
    logic signed [IW-1:0] y0, y1, y2, y3, dc;
    logic [CW-1:0]        y0_raw, y1_raw, y2_raw, y3_raw;

    // Y4..Y7 are carried on the bus but never used by this stage.
    logic unused_coef;
    assign unused_coef = ^in_coef[39:0];

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_sat   = out_sat_q;
    assign out_last  = out_valid_q && (col_q == 3'd7);

    assign y0_raw = in_coef[79:70];
    assign y1_raw = in_coef[69:60];
    assign y2_raw = in_coef[59:50];
    assign y3_raw = in_coef[49:40];

    // S1: sign-extend the coefficients and form the even and odd butterfly terms
    always_comb begin
        y0 = IW'($signed(y0_raw));
        y1 = IW'($signed(y1_raw));
        y2 = IW'($signed(y2_raw));
        y3 = IW'($signed(y3_raw));
        dc = (count1 == HI_GAIN_ROW) ? (y0 <<< 2) : y0;

        e_d[0] = dc + y2;
        e_d[1] = dc + (y2 >>> 1);
        e_d[2] = dc - (y2 >>> 1);
        e_d[3] = dc - y2;

        o_d[0] = y1 + y3;
        o_d[1] = y1 - (y3 >>> 1);
        o_d[2] = (y1 >>> 1) - y3;
        o_d[3] = (y1 >>> 2) - (y3 >>> 1);
    end

    // S2: output butterfly, clipping every sample to the 9-bit signed range
    always_comb begin
        logic signed [IW-1:0] sum;
        logic signed [IW-1:0] dif;
        pix_d = '0;
        sat_d = 1'b0;
        sum   = '0;
        dif   = '0;
        for (int n = 0; n < NT; n++) begin
            sum = e_q[n] + o_q[n];
            dif = e_q[n] - o_q[n];
            if (sum > PIX_MAX) begin
                pix_d[(7-n)*PW +: PW] = PW'(PIX_MAX);
                sat_d = 1'b1;
            end else if (sum < PIX_MIN) begin
                pix_d[(7-n)*PW +: PW] = PW'(PIX_MIN);
                sat_d = 1'b1;
            end else begin
                pix_d[(7-n)*PW +: PW] = PW'(sum);
            end
            if (dif > PIX_MAX) begin
                pix_d[n*PW +: PW] = PW'(PIX_MAX);
                sat_d = 1'b1;
            end else if (dif < PIX_MIN) begin
                pix_d[n*PW +: PW] = PW'(PIX_MIN);
                sat_d = 1'b1;
            end else begin
                pix_d[n*PW +: PW] = PW'(dif);
            end
        end
    end

    // Pipeline registers: both stages shift together when en, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_sat_q   <= 1'b0;
            for (int n = 0; n < NT; n++) begin
                e_q[n] <= '0;
                o_q[n] <= '0;
            end
        end else if (en) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            out_pix_q   <= pix_d;
            out_sat_q   <= sat_d;
            for (int n = 0; n < NT; n++) begin
                e_q[n] <= e_d[n];
                o_q[n] <= o_d[n];
            end
        end
    end

    // Column counter advances on each output transfer and wraps 7 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= 3'd0;
        end else if (out_valid_q && out_ready) begin
            col_q <= col_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_idct_1d_column1.sv
// Randomised and directed bench for idct_1d_column1, checked against a reference model.
module tb_idct_1d_column1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [79:0] in_coef = '0;
    logic [2:0]  count1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [71:0] out_pix;
    logic        out_last;
    logic        out_sat;

    idct_1d_column1 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .count1    (count1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: stage occupancy, expected outputs in order, and the column number
    logic        m_s1v = 1'b0;
    logic        m_ov  = 1'b0;
    logic [71:0] sb_pix [$];
    logic        sb_sat [$];
    int          m_col = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clip(input int v, inout logic s);
        if (v > 255) begin s = 1'b1; return 255; end
        if (v < -256) begin s = 1'b1; return -256; end
        return v;
    endfunction

    // Column IDCT computed directly from the coefficients with plain integers
    function automatic void ref_model(input logic [79:0] c, input logic [2:0] cn,
                                      output logic [71:0] pix, output logic sat);
        int y0, y1, y2, y3, d;
        int e [4];
        int o [4];
        int x [8];
        y0 = int'($signed(c[79:70]));
        y1 = int'($signed(c[69:60]));
        y2 = int'($signed(c[59:50]));
        y3 = int'($signed(c[49:40]));
        d  = (cn == 3'b010) ? y0 * 4 : y0;
        e[0] = d + y2;  e[1] = d + (y2 >>> 1);
        e[2] = d - (y2 >>> 1);  e[3] = d - y2;
        o[0] = y1 + y3; o[1] = y1 - (y3 >>> 1);
        o[2] = (y1 >>> 1) - y3; o[3] = (y1 >>> 2) - (y3 >>> 1);
        sat = 1'b0;
        for (int n = 0; n < 4; n++) begin
            x[n]     = clip(e[n] + o[n], sat);
            x[7 - n] = clip(e[n] - o[n], sat);
        end
        pix = '0;
        for (int k = 0; k < 8; k++) pix[(7 - k) * 9 +: 9] = 9'(x[k]);
    endfunction

    function automatic logic [79:0] mk(input int a0, input int a1, input int a2, input int a3);
        return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 40'd0};
    endfunction

    // One clock cycle: drive, check at negedge, advance the occupancy model at posedge
    task automatic step(input logic v, input logic [79:0] c, input logic [2:0] cn,
                        input logic ordy, input logic has_exp,
                        input logic [71:0] xp, input logic xs);
        logic        en_m;
        logic [71:0] mp;
        logic        ms;
        in_valid  = v;
        in_coef   = c;
        count1    = cn;
        out_ready = ordy;
        @(negedge clk);
        en_m = !m_ov || ordy;
        check("in_ready", 72'(in_ready), 72'(en_m));
        check("out_valid", 72'(out_valid), 72'(m_ov));
        if (m_ov && sb_pix.size() > 0) begin
            check("out_pix", out_pix, sb_pix[0]);
            check("out_sat", 72'(out_sat), 72'(sb_sat[0]));
            check("out_last", 72'(out_last), 72'(m_col == 7));
            if (ordy) begin
                void'(sb_pix.pop_front());
                void'(sb_sat.pop_front());
                m_col = (m_col + 1) % 8;
            end
        end else begin
            check("out_last_idle", 72'(out_last), 72'(0));
        end
        if (v && en_m) begin
            if (has_exp) begin
                mp = xp; ms = xs;
            end else begin
                ref_model(c, cn, mp, ms);
            end
            sb_pix.push_back(mp);
            sb_sat.push_back(ms);
        end
        @(posedge clk);
        if (en_m) begin
            m_ov  = m_s1v;
            m_s1v = v;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 3'd0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic rnd_vec(input logic ordy);
        logic [79:0] c;
        logic [2:0]  cn;
        c  = {$urandom, $urandom, 16'($urandom)};
        cn = ($urandom_range(0, 3) == 0) ? 3'b010 : 3'($urandom);
        step(1'b1, c, cn, ordy, 1'b0, '0, 1'b0);
    endtask

    // Assert reset asynchronously, verify cleared outputs, discard everything in flight
    task automatic do_reset;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_out_pix", out_pix, 72'(0));
        check("rst_out_last", 72'(out_last), 72'(0));
        check("rst_out_sat", 72'(out_sat), 72'(0));
        check("rst_in_ready", 72'(in_ready), 72'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_s1v = 1'b0;
        m_ov  = 1'b0;
        m_col = 0;
        sb_pix.delete();
        sb_sat.delete();
    endtask

    initial begin
        in_valid = 1'b0;
        do_reset();

        // DC-only, normal and high-gain rows, saturation both ways, odd-only input
        step(1'b1, mk(10, 0, 0, 0), 3'd0, 1'b1, 1'b1, {8{9'd10}}, 1'b0);
        idle(3);
        step(1'b1, mk(10, 0, 0, 0), 3'b010, 1'b1, 1'b1, {8{9'd40}}, 1'b0);
        step(1'b1, mk(200, 0, 0, 0), 3'b010, 1'b1, 1'b1, {8{9'h0FF}}, 1'b1);
        step(1'b1, mk(-200, 0, 0, 0), 3'b010, 1'b1, 1'b1, {8{9'h100}}, 1'b1);
        step(1'b1, mk(0, 8, 0, 0), 3'd0, 1'b1, 1'b1,
             {9'd8, 9'd8, 9'd4, 9'd2, 9'h1FE, 9'h1FC, 9'h1F8, 9'h1F8}, 1'b0);
        idle(3);

        // Realign the column count, then nine back-to-back vectors (wrap check)
        do_reset();
        for (int i = 0; i < 9; i++) rnd_vec(1'b1);
        idle(3);

        // Back-pressure: three stalled cycles while streaming
        for (int i = 0; i < 4; i++) rnd_vec(1'b1);
        for (int i = 0; i < 3; i++) rnd_vec(1'b0);
        for (int i = 0; i < 4; i++) rnd_vec(1'b1);
        idle(3);

        // Reset with two vectors in flight; the next output must be column 0
        rnd_vec(1'b1);
        rnd_vec(1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) rnd_vec(1'b1);
        idle(3);

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic        r;
            logic [79:0] c;
            logic [2:0]  cn;
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 3) != 0);
            c  = {$urandom, $urandom, 16'($urandom)};
            cn = ($urandom_range(0, 3) == 0) ? 3'b010 : 3'($urandom);
            step(v, c, cn, r, 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 20 && sb_pix.size() > 0; i++) idle(1);
        check("drained", 72'(sb_pix.size()), 72'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
